// File: rtl/sdram_tg_pkg.sv
// sdram_tg_pkg: mode/state encodings shared by the traffic generator
package sdram_tg_pkg;
    localparam int ERR_W = 16;
    typedef enum logic [1:0] {TG_MODE_SEQ, TG_MODE_INTLV, TG_MODE_WRONLY, TG_MODE_RDONLY} tg_mode_e;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} tg_state_e;
endpackage

// File: rtl/sdram_traffic_gen_if.sv
// sdram_traffic_gen_if: system-side az_/za_ bus between generator and SDRAM controller
interface sdram_traffic_gen_if #(parameter int ADDR_W = 22, DATA_W = 16, BE_W = DATA_W / 8);
    logic az_cs, az_rd_n, az_wr_n;
    logic [BE_W-1:0] az_be_n;
    logic [ADDR_W-1:0] az_addr;
    logic [DATA_W-1:0] az_data, za_data;
    logic za_valid, za_wait;
    modport master(output az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data, input za_valid, za_wait, za_data);
    modport slave(input az_cs, az_rd_n, az_wr_n, az_be_n, az_addr, az_data, output za_valid, za_wait, za_data);
endinterface

// File: rtl/tg_expect_fifo.sv
// tg_expect_fifo: in-order queue of expected read entries, sized to the outstanding limit
module tg_expect_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        wp_d = push ? inc(wp_q) : wp_q;
        rp_d = pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) if (push) mem[wp_q] <= din;
    assign dout = mem[rp_q];
    assign count = cnt_q;
endmodule

// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen: az_/za_ pattern writer/checker; define TG_ERR_LOG_EN for first-error capture
module sdram_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int BE_W = DATA_W / 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int NUM_WORDS = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [1:0] mode,
    input  logic [DATA_W-1:0] seed,
    output logic running,
    output logic done,
    output logic pass,
    output logic [ERR_W-1:0] err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_act,
    sdram_traffic_gen_if.master bus
);
    localparam int IW = $clog2(NUM_WORDS) + 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
`ifdef TG_ERR_LOG_EN
    localparam int FW = DATA_W + ADDR_W;
`else
    localparam int FW = DATA_W;
`endif
    tg_state_e state_q, state_d;
    tg_mode_e mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d, exp_data;
    logic [IW-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ADDR_W-1:0] addr;
    logic [FW-1:0] fifo_din, fifo_dout;
    logic [CW-1:0] outstanding;
    logic wr_req, rd_req, accept, last, pop, mismatch, bad, go;

    assign addr = START_ADDR + ADDR_W'(idx_q);
    assign exp_data = DATA_W'(addr) ^ seed_q;
    assign last = idx_q == IW'(NUM_WORDS - 1);
    assign running = state_q inside {ST_WRITE, ST_READ, ST_DRAIN};
    assign go = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign wr_req = state_q == ST_WRITE;
    assign rd_req = state_q == ST_READ && outstanding < CW'(MAX_OUTSTANDING);
    assign accept = (wr_req || rd_req) && !bus.za_wait;
    assign pop = bus.za_valid && running && outstanding != '0;
    assign mismatch = pop && fifo_dout[DATA_W-1:0] != bus.za_data;
    // a return with nothing expected is as much a failure as wrong data
    assign bad = mismatch || (bus.za_valid && running && outstanding == '0);

    assign bus.az_cs = wr_req || rd_req;
    assign bus.az_wr_n = !wr_req;
    assign bus.az_rd_n = !rd_req;
    assign bus.az_be_n = (wr_req || rd_req) ? '0 : {BE_W{1'b1}};
    assign bus.az_addr = (wr_req || rd_req) ? addr : '0;
    assign bus.az_data = wr_req ? exp_data : '0;
    assign done = state_q == ST_DONE;
    assign pass = done && err_q == '0;
    assign err_count = err_q;

    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        seed_d = seed_q;
        idx_d = idx_q;
        err_d = bad && err_q != '1 ? err_q + 1'b1 : err_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) begin
                state_d = mode == TG_MODE_RDONLY ? ST_READ : ST_WRITE;
                mode_d = tg_mode_e'(mode);
                seed_d = seed;
                idx_d = '0;
                err_d = '0;
            end
            ST_WRITE: if (accept) begin
                state_d = mode_q == TG_MODE_INTLV ? ST_READ : !last ? ST_WRITE :
                          mode_q == TG_MODE_WRONLY ? ST_DONE : ST_READ;
                idx_d = mode_q == TG_MODE_INTLV ? idx_q : last ? '0 : idx_q + 1'b1;
            end
            ST_READ: if (accept) begin
                state_d = last ? ST_DRAIN : mode_q == TG_MODE_INTLV ? ST_WRITE : ST_READ;
                idx_d = idx_q + 1'b1;
            end
            // leave on the compare edge itself so done follows the last compare by one cycle
            ST_DRAIN: if (outstanding == '0 || (outstanding == CW'(1) && pop)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q <= TG_MODE_SEQ;
            seed_q <= '0;
            idx_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            seed_q <= seed_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    tg_expect_fifo #(.W(FW), .DEPTH(MAX_OUTSTANDING), .CW(CW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept && rd_req),
        .pop(pop),
        .din(fifo_din),
        .dout(fifo_dout),
        .count(outstanding)
    );

`ifdef TG_ERR_LOG_EN
    logic log_v_q, log_v_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [DATA_W-1:0] ee_q, ee_d, eact_q, eact_d;
    assign fifo_din = {addr, exp_data};
    always_comb begin
        log_v_d = go ? 1'b0 : log_v_q || mismatch;
        ea_d = go ? '0 : mismatch && !log_v_q ? fifo_dout[FW-1:DATA_W] : ea_q;
        ee_d = go ? '0 : mismatch && !log_v_q ? fifo_dout[DATA_W-1:0] : ee_q;
        eact_d = go ? '0 : mismatch && !log_v_q ? bus.za_data : eact_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            log_v_q <= 1'b0;
            ea_q <= '0;
            ee_q <= '0;
            eact_q <= '0;
        end else begin
            log_v_q <= log_v_d;
            ea_q <= ea_d;
            ee_q <= ee_d;
            eact_q <= eact_d;
        end
    end
    assign err_addr = ea_q;
    assign err_exp = ee_q;
    assign err_act = eact_q;
`else
    assign fifo_din = exp_data;
    assign err_addr = '0;
    assign err_exp = '0;
    assign err_act = '0;
`endif
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb_sdram_traffic_gen: request-trace scoreboard against a reactive az_/za_ slave model
module tb_sdram_traffic_gen;
    localparam logic [21:0] BASE = 22'h3FFFFC;
    localparam int N = 8;
    typedef struct packed {logic wr; logic [21:0] addr; logic [15:0] data;} req_t;
    typedef struct packed {int due; logic [15:0] data;} rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [15:0] seed = '0;
    logic running, done, pass;
    logic [15:0] err_count, err_exp, err_act;
    logic [21:0] err_addr;
    int total = 0, bad = 0;
    req_t exp_q[$];
    rsp_t rsp_q[$];
    logic [15:0] mem [16];
    int cyc = 0, lat = 2, stall_left = 0, wr_seen = 0, inflight = 0, max_inflight = 0;
    int last_vld = -1, done_cyc = -1;
    bit stall_en = 1'b0, stalled = 1'b0, corrupt_en = 1'b0;
    logic [21:0] hold_addr;
    logic [15:0] hold_data;

    sdram_traffic_gen_if #(.ADDR_W(22), .DATA_W(16)) bus ();

    sdram_traffic_gen #(.START_ADDR(BASE), .NUM_WORDS(N), .MAX_OUTSTANDING(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .seed(seed),
        .running(running),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .err_addr(err_addr),
        .err_exp(err_exp),
        .err_act(err_act),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [21:0] a, input logic [15:0] s);
        return a[15:0] ^ s;
    endfunction

    // expected request trace for one run, in issue order
    task automatic plan(input logic [1:0] m, input logic [15:0] s);
        for (int i = 0; i < N; i++) begin
            logic [21:0] a;
            a = BASE + 22'(i);
            if (m != 2'd3) exp_q.push_back('{1'b1, a, pat(a, s)});
            if (m == 2'd1) exp_q.push_back('{1'b0, a, 16'h0});
        end
        if (m == 2'd0 || m == 2'd3)
            for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, BASE + 22'(i), 16'h0});
    endtask

    always @(negedge clk) begin : slave
        req_t e;
        logic [15:0] d;
        cyc++;
        bus.za_valid = 1'b0;
        bus.za_data = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            bus.za_valid = 1'b1;
            bus.za_data = rsp_q[0].data;
            void'(rsp_q.pop_front());
            inflight--;
            last_vld = cyc;
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        bus.za_wait = 1'b0;
        if (bus.az_cs === 1'b1) begin
            if (stall_left > 0) begin
                stall_left--;
                bus.za_wait = 1'b1;
                chk("stall_addr", 32'(bus.az_addr), 32'(hold_addr));
                chk("stall_data", 32'(bus.az_data), 32'(hold_data));
            end else if (stall_en && !stalled && bus.az_wr_n === 1'b0 && wr_seen == 2) begin
                stalled = 1'b1;
                stall_left = 4;
                bus.za_wait = 1'b1;
                hold_addr = bus.az_addr;
                hold_data = bus.az_data;
            end
            if (!bus.za_wait) begin
                chk("req_expected", 32'(exp_q.size() != 0), 1);
                chk("req_onehot", 32'(bus.az_rd_n ^ bus.az_wr_n), 1);
                chk("req_be", 32'(bus.az_be_n), 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("req_dir", 32'(!bus.az_wr_n), 32'(e.wr));
                    chk("req_addr", 32'(bus.az_addr), 32'(e.addr));
                    if (e.wr) chk("req_data", 32'(bus.az_data), 32'(e.data));
                end
                if (bus.az_wr_n === 1'b0) begin
                    mem[bus.az_addr[3:0]] = bus.az_data;
                    wr_seen++;
                end else begin
                    d = mem[bus.az_addr[3:0]];
                    if (corrupt_en && bus.az_addr == 22'h000001) d[0] = ~d[0];
                    rsp_q.push_back('{cyc + lat, d});
                    inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_cs"}, 32'(bus.az_cs), 0);
        chk({tag, "_rd_n"}, 32'(bus.az_rd_n), 1);
        chk({tag, "_wr_n"}, 32'(bus.az_wr_n), 1);
        chk({tag, "_be_n"}, 32'(bus.az_be_n), 3);
        chk({tag, "_addr"}, 32'(bus.az_addr), 0);
        chk({tag, "_data"}, 32'(bus.az_data), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
    endtask

    task automatic begin_run(input logic [1:0] m, input logic [15:0] s);
        plan(m, s);
        wr_seen = 0;
        stalled = 1'b0;
        max_inflight = 0;
        @(negedge clk);
        mode = m;
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        seed = ~s;
        done_cyc = -1;
        last_vld = -1;
        chk("start_running", 32'(running), 1);
        chk("start_req", 32'(bus.az_cs), 1);
    endtask

    task automatic finish_run(input string tag, input logic [1:0] m, input int exp_err);
        for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        chk({tag, "_err"}, 32'(err_count), exp_err);
        chk({tag, "_trace_left"}, exp_q.size(), 0);
        if (m != 2'd2) chk({tag, "_done_lat"}, done_cyc - last_vld, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        begin_run(2'd0, 16'h00FF);
        finish_run("seq", 2'd0, 0);
        stall_en = 1'b1;
        begin_run(2'd0, 16'h1234);
        finish_run("stall", 2'd0, 0);
        stall_en = 1'b0;
        chk("stall_hit", 32'(stalled), 1);
        lat = 10;
        begin_run(2'd0, 16'hC3C3);
        repeat (6) @(negedge clk);
        start = 1'b1;
        mode = 2'd2;
        seed = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        finish_run("lat10", 2'd0, 0);
        chk("max_inflight", max_inflight, 4);
        lat = 2;
        corrupt_en = 1'b1;
        begin_run(2'd0, 16'hA5A5);
        finish_run("corrupt", 2'd0, 1);
        corrupt_en = 1'b0;
`ifdef TG_ERR_LOG_EN
        chk("log_addr", 32'(err_addr), 32'h000001);
        chk("log_exp", 32'(err_exp), 32'hA5A4);
        chk("log_act", 32'(err_act), 32'hA5A5);
`else
        chk("log_addr", 32'(err_addr), 0);
        chk("log_exp", 32'(err_exp), 0);
        chk("log_act", 32'(err_act), 0);
`endif
        begin_run(2'd2, 16'h0F0F);
        finish_run("wronly", 2'd2, 0);
        begin_run(2'd3, 16'h0F0F);
        finish_run("rdonly", 2'd3, 0);
        begin_run(2'd3, 16'h0F0E);
        finish_run("rdbad", 2'd3, 8);
        lat = 4;
        begin_run(2'd1, 16'h5A5A);
        for (int i = 0; i < 200 && wr_seen < 4; i++) @(negedge clk);
        chk("abort_w3", wr_seen, 4);
        chk("abort_inflight", 32'(inflight != 0), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("abort");
        chk("abort_late_pending", 32'(rsp_q.size() != 0), 1);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 100 && rsp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("abort_drained", rsp_q.size(), 0);
        chk("abort_err", 32'(err_count), 0);
        chk("abort_running", 32'(running), 0);
        chk("abort_cs", 32'(bus.az_cs), 0);
        lat = 2;
        begin_run(2'd0, 16'h7E7E);
        finish_run("after", 2'd0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
